stb_trace_buffer: RTL and testbench
===================================

Name: stb_trace_buffer

Overview:
- Circular trace buffer that sits directly upstream of the DTM's STB0/STB1 channel; one instance per channel.
- Captures DATA_WIDTH-bit trace words from the core and holds them until the DTM drains them over the STB data read handshake.
- Reports buffer state on the STB status handshake.
- Accepts control bytes, and marker words injected by the DTM over the STB data write handshake.

Parameters:
- DEPTH, 64, buffer entries; power of two, >= 4.
- DATA_WIDTH, 32, trace/data word width (matches STB_DATA_WIDTH).
- CONTROL_WIDTH, 8, control byte width.
- STATUS_WIDTH, 8, status byte width.
- POST_TRIGGER, 16, words captured after trigger before freezing; 1..DEPTH.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous, active-high reset.
- TRACE_VALID_I  in  1  core trace word present; no backpressure.
- TRACE_DATA_I  in  DATA_WIDTH  trace word.
- TRIGGER_I  in  1  trigger event, sampled each cycle.
- CONTROL_VALID_I  in  1  control byte from DTM.
- CONTROL_READY_O  out  1  control accept.
- CONTROL_I  in  CONTROL_WIDTH  control byte.
- STATUS_VALID_O  out  1  status available.
- STATUS_READY_I  in  1  DTM takes status.
- STATUS_O  out  STATUS_WIDTH  status byte.
- DATA_VALID_O  out  1  oldest word available.
- DATA_READY_I  in  1  DTM pops word.
- DATA_O  out  DATA_WIDTH  oldest buffered word.
- INJECT_VALID_I  in  1  marker word from DTM.
- INJECT_READY_O  out  1  marker accept.
- INJECT_I  in  DATA_WIDTH  marker word.

Behaviour:
- Reset:
  - One clock CLK_I; RST_I synchronous, active-high.
  - On reset: state OFF; pointers and level 0; OVERFLOW and TRIGGERED cleared.
  - All outputs 0 during reset; STATUS_VALID_O and CONTROL_READY_O become 1 the cycle after RST_I deasserts.
  - Memory contents are not reset.
  - Reset mid-capture discards everything.
- Control byte, accepted when CONTROL_VALID_I && CONTROL_READY_O:
  - bit0 ENABLE.
  - bit1 CLEAR (action, not stored).
  - bit2 STOP_ON_FULL.
  - bit3 ARM.
  - Other bits ignored.
  - ENABLE, STOP_ON_FULL and ARM are stored.
  - CONTROL_READY_O is constant 1 after reset.
- CLEAR: pointers, level, OVERFLOW and TRIGGERED zeroed on the accept edge. A push or pop in the same cycle is discarded.
- State machine, next-state priority reset > control > trigger > full:
  - OFF -> RUN: control accept with ENABLE=1.
  - Any state -> OFF: control accept with ENABLE=0.
  - RUN -> POST: ARM && TRIGGER_I; TRIGGERED is set and the word on that cycle, if valid, is captured and counted.
  - POST: a down-counter loaded with POST_TRIGGER decrements per captured word; -> FROZEN when it reaches 0. TRIGGER_I is ignored in POST.
  - RUN -> FROZEN: STOP_ON_FULL && full && TRACE_VALID_I && no pop; the word is dropped and OVERFLOW is set.
  - FROZEN -> RUN: control accept with ENABLE=1. Buffer contents are kept.
- Capture:
  - Occurs in RUN/POST only.
  - In OFF/FROZEN, trace words are ignored and do not set OVERFLOW.
- Push source:
  - TRACE_VALID_I has priority.
  - INJECT_READY_O = !(capturing && TRACE_VALID_I) && !(full && STOP_ON_FULL).
  - An inject is stored in any state, including OFF/FROZEN.
- Full, wrap mode (STOP_ON_FULL=0):
  - Push without pop overwrites the oldest entry: both pointers advance, level stays DEPTH, OVERFLOW set.
  - Push with simultaneous pop: normal push+pop, no overflow.
- Full, stop mode (STOP_ON_FULL=1):
  - Push with simultaneous pop succeeds.
  - A trace push without pop causes the RUN -> FROZEN transition above.
- Readout:
  - Show-ahead: DATA_VALID_O = level != 0; DATA_O = mem[rd_ptr].
  - Pop on DATA_VALID_O && DATA_READY_I, allowed in every state.
  - Word pushed at cycle N into an empty buffer is visible at N+1.
  - Pop on empty is a no-op.
- Level and pointers:
  - Level counter is clog2(DEPTH)+1 bits; it never exceeds DEPTH or underflows.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
- Status register, recomputed every cycle and presented one cycle after the event:
  - [0] EMPTY.
  - [1] FULL.
  - [2] OVERFLOW (sticky until CLEAR or reset).
  - [3] TRIGGERED (sticky).
  - [5:4] state: OFF=0, RUN=1, POST=2, FROZEN=3.
  - [7:6] level quartile = min(3, level*4/DEPTH).
  - STATUS_READY_I has no side effects.

Decomposition:
- Shared package stb_pkg:
  - Control bit index constants (STB_CTRL_ENABLE/CLEAR/STOP/ARM).
  - Status bit index constants.
  - Enum stb_state_e {OFF, RUN, POST, FROZEN}.
- Sub-module stb_ring_fifo:
  - Memory, pointers and level.
  - Push, pop, overwrite-when-full and clear inputs.
  - Empty/full/level outputs.
- Top holds the state machine, post-trigger counter, push arbitration and status.

Test Plan:
- Enable (ctrl 0x01), push 3 words 0xA0..0xA2, DTM pops -> DATA_O 0xA0,0xA1,0xA2 in order; first valid 1 cycle after first push; status 0x11 (RUN, EMPTY) at end.
- Wrap mode, DEPTH=64, push 70 words 0..69, no pops -> level 64; OVERFLOW=1; drain yields 6..69; status[7:6] goes 3 -> 0.
- ctrl 0x05, 65 pushes without pop -> state FROZEN (status[5:4]=3) on 65th; word 64 dropped; pops yield 0..63; ctrl 0x01 resumes RUN.
- ctrl 0x09, trigger after 10 words, continuous trace -> exactly 10+POST_TRIGGER(16)=26 words stored; FROZEN; TRIGGERED=1; further trace ignored.
- Inject 0xDEADBEEF while TRACE_VALID_I=1 -> INJECT_READY_O=0 until the trace gap; marker lands after the preceding trace word; inject in OFF stored.
- Full wrap buffer with push+pop same cycle -> no overflow. CLEAR (0x03) mid-capture -> empty next cycle, flags zero, state RUN. RST_I mid-capture -> all outputs 0.

Source files
------------

// File: rtl/stb_pkg.sv
// Shared definitions for the STB trace buffer: control/status bit positions
// and the capture state encoding reported in status[5:4].
package stb_pkg;

  localparam int STB_CTRL_ENABLE = 0;
  localparam int STB_CTRL_CLEAR  = 1;
  localparam int STB_CTRL_STOP   = 2;
  localparam int STB_CTRL_ARM    = 3;

  localparam int STB_STAT_EMPTY     = 0;
  localparam int STB_STAT_FULL      = 1;
  localparam int STB_STAT_OVERFLOW  = 2;
  localparam int STB_STAT_TRIGGERED = 3;
  localparam int STB_STAT_STATE_LSB = 4;
  localparam int STB_STAT_QUART_LSB = 6;

  typedef enum logic [1:0] {
    STB_OFF    = 2'd0,
    STB_RUN    = 2'd1,
    STB_POST   = 2'd2,
    STB_FROZEN = 2'd3
  } stb_state_e;

endpackage

// File: rtl/stb_ring_fifo.sv
// Circular word store with show-ahead read; a push into a full ring without
// a pop overwrites the oldest entry. Clear wins over a same-cycle push/pop.
module stb_ring_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             do_pop;
  logic             overwrite;

  assign empty     = (level_q == '0);
  assign full      = (level_q == (AW+1)'(DEPTH));
  assign level     = level_q;
  assign rd_data   = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  assign overwrite = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (push && !clear && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // Overwrite drags the read pointer along so the oldest word is lost.
      if (do_pop || overwrite) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (!overwrite) begin
        level_q <= level_q + (AW+1)'(push) - (AW+1)'(do_pop);
      end
    end
  end

endmodule

// File: rtl/stb_trace_buffer.sv
// Trace buffer in front of one DTM STB channel: capture state machine,
// post-trigger countdown, trace/inject push arbitration and status byte.
module stb_trace_buffer
  import stb_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 8,
  parameter int STATUS_WIDTH  = 8,
  parameter int POST_TRIGGER  = 16
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     TRACE_VALID_I,
  input  logic [DATA_WIDTH-1:0]    TRACE_DATA_I,
  input  logic                     TRIGGER_I,
  input  logic                     CONTROL_VALID_I,
  output logic                     CONTROL_READY_O,
  input  logic [CONTROL_WIDTH-1:0] CONTROL_I,
  output logic                     STATUS_VALID_O,
  input  logic                     STATUS_READY_I,
  output logic [STATUS_WIDTH-1:0]  STATUS_O,
  output logic                     DATA_VALID_O,
  input  logic                     DATA_READY_I,
  output logic [DATA_WIDTH-1:0]    DATA_O,
  input  logic                     INJECT_VALID_I,
  output logic                     INJECT_READY_O,
  input  logic [DATA_WIDTH-1:0]    INJECT_I
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(POST_TRIGGER + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and status reads have no effect.
  logic                    ready_q;
  stb_state_e              state_q, state_d;
  logic [CW-1:0]           post_cnt_q, post_cnt_d;
  logic                    stop_q, arm_q, overflow_q, triggered_q;
  logic [STATUS_WIDTH-1:0] status_q, status_d;

  logic [DATA_WIDTH-1:0]   fifo_rd_data;
  logic                    fifo_empty, fifo_full;
  logic [AW:0]             fifo_level;

  logic ctrl_acc, ctrl_clear, capturing, pop, stop_drop, trace_push;
  logic inj_push, push, wrap_ovf, trig_hit;
  logic [1:0] quart;
  logic lint_unused;

  assign lint_unused = ^{STATUS_READY_I, CONTROL_I[CONTROL_WIDTH-1:4]};

  assign ctrl_acc   = CONTROL_VALID_I && ready_q;
  assign ctrl_clear = ctrl_acc && CONTROL_I[STB_CTRL_CLEAR];
  assign capturing  = (state_q == STB_RUN) || (state_q == STB_POST);
  assign pop        = !fifo_empty && DATA_READY_I;
  // Stop mode never overwrites: an unpoppable trace word freezes capture.
  assign stop_drop  = capturing && TRACE_VALID_I && stop_q && fifo_full && !pop;
  assign trace_push = capturing && TRACE_VALID_I && !stop_drop;
  assign INJECT_READY_O = ready_q && !(capturing && TRACE_VALID_I) && !(fifo_full && stop_q);
  assign inj_push   = INJECT_VALID_I && INJECT_READY_O;
  assign push       = trace_push || inj_push;
  assign wrap_ovf   = push && fifo_full && !pop;
  assign trig_hit   = (state_q == STB_RUN) && arm_q && TRIGGER_I;

  assign CONTROL_READY_O = ready_q;
  assign STATUS_VALID_O  = ready_q;
  assign STATUS_O        = status_q;
  assign DATA_VALID_O    = !fifo_empty;
  assign DATA_O          = fifo_empty ? '0 : fifo_rd_data;

  stb_ring_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (CLK_I),
    .rst       (RST_I),
    .clear     (ctrl_clear),
    .push      (push),
    .push_data (trace_push ? TRACE_DATA_I : INJECT_I),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    if (state_q == STB_POST && trace_push) begin
      post_cnt_d = post_cnt_q - CW'(1);
    end
    if (ctrl_acc) begin
      if (!CONTROL_I[STB_CTRL_ENABLE]) begin
        state_d = STB_OFF;
      end else if (state_q == STB_OFF || state_q == STB_FROZEN) begin
        state_d = STB_RUN;
      end
    end else if (trig_hit) begin
      // The trigger-cycle word already counts toward the post-trigger window.
      post_cnt_d = trace_push ? CW'(POST_TRIGGER - 1) : CW'(POST_TRIGGER);
      state_d    = (trace_push && POST_TRIGGER == 1) ? STB_FROZEN : STB_POST;
    end else if (state_q == STB_POST && trace_push && post_cnt_q <= CW'(1)) begin
      state_d = STB_FROZEN;
    end else if (stop_drop) begin
      state_d = STB_FROZEN;
    end
  end

  always_comb begin
    if (fifo_level >= (AW+1)'(3 * DEPTH / 4))  quart = 2'd3;
    else if (fifo_level >= (AW+1)'(DEPTH / 2)) quart = 2'd2;
    else if (fifo_level >= (AW+1)'(DEPTH / 4)) quart = 2'd1;
    else                                       quart = 2'd0;
    status_d = '0;
    status_d[STB_STAT_EMPTY]              = fifo_empty;
    status_d[STB_STAT_FULL]               = fifo_full;
    status_d[STB_STAT_OVERFLOW]           = overflow_q;
    status_d[STB_STAT_TRIGGERED]          = triggered_q;
    status_d[STB_STAT_STATE_LSB +: 2]     = state_q;
    status_d[STB_STAT_QUART_LSB +: 2]     = quart;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ready_q     <= 1'b0;
      state_q     <= STB_OFF;
      post_cnt_q  <= '0;
      stop_q      <= 1'b0;
      arm_q       <= 1'b0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
      status_q    <= '0;
    end else begin
      ready_q    <= 1'b1;
      state_q    <= state_d;
      post_cnt_q <= post_cnt_d;
      status_q   <= status_d;
      if (ctrl_acc) begin
        stop_q <= CONTROL_I[STB_CTRL_STOP];
        arm_q  <= CONTROL_I[STB_CTRL_ARM];
      end
      if (ctrl_clear) begin
        overflow_q  <= 1'b0;
        triggered_q <= 1'b0;
      end else begin
        if (stop_drop || wrap_ovf) overflow_q  <= 1'b1;
        if (trig_hit && !ctrl_acc) triggered_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stb_trace_buffer.sv
// Directed bench for stb_trace_buffer (DEPTH=64, POST_TRIGGER=16): each task
// drives one scenario and compares outputs against hand-computed values.
module tb_stb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_valid;
  logic [31:0] trace_data;
  logic        trigger;
  logic        control_valid;
  logic        control_ready;
  logic [7:0]  control;
  logic        status_valid;
  logic        status_ready;
  logic [7:0]  status;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data;
  logic        inject_valid;
  logic        inject_ready;
  logic [31:0] inject;

  int checks = 0;
  int errors = 0;

  stb_trace_buffer dut (
    .CLK_I           (clk),
    .RST_I           (rst),
    .TRACE_VALID_I   (trace_valid),
    .TRACE_DATA_I    (trace_data),
    .TRIGGER_I       (trigger),
    .CONTROL_VALID_I (control_valid),
    .CONTROL_READY_O (control_ready),
    .CONTROL_I       (control),
    .STATUS_VALID_O  (status_valid),
    .STATUS_READY_I  (status_ready),
    .STATUS_O        (status),
    .DATA_VALID_O    (data_valid),
    .DATA_READY_I    (data_ready),
    .DATA_O          (data),
    .INJECT_VALID_I  (inject_valid),
    .INJECT_READY_O  (inject_ready),
    .INJECT_I        (inject)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_write(input logic [7:0] b);
    control_valid = 1'b1;
    control       = b;
    step();
    control_valid = 1'b0;
    control       = 8'h00;
  endtask

  task automatic push_trace(input logic [31:0] d);
    trace_valid = 1'b1;
    trace_data  = d;
    step();
    trace_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid got=%b exp=0", data_valid); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", data); end
    checks++; if (status_valid !== 1'b0) begin errors++; $display("FAIL rst_status_valid got=%b exp=0", status_valid); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL rst_status got=%h exp=00", status); end
    checks++; if (control_ready !== 1'b0) begin errors++; $display("FAIL rst_control_ready got=%b exp=0", control_ready); end
    checks++; if (inject_ready !== 1'b0) begin errors++; $display("FAIL rst_inject_ready got=%b exp=0", inject_ready); end
    rst = 1'b0;
    step();
    checks++; if (status_valid !== 1'b1) begin errors++; $display("FAIL post_rst_status_valid got=%b exp=1", status_valid); end
    checks++; if (control_ready !== 1'b1) begin errors++; $display("FAIL post_rst_control_ready got=%b exp=1", control_ready); end
    checks++; if (status !== 8'h01) begin errors++; $display("FAIL post_rst_status got=%h exp=01", status); end
  endtask

  task automatic test_basic();
    ctrl_write(8'h01);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", data_valid); end
    trace_valid = 1'b1;
    trace_data  = 32'hA0;
    step();
    checks++; if (data_valid !== 1'b1 || data !== 32'hA0) begin errors++; $display("FAIL basic_first_visible got=%b/%h exp=1/a0", data_valid, data); end
    trace_data = 32'hA1;
    step();
    trace_data = 32'hA2;
    step();
    trace_valid = 1'b0;
    data_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (data !== 32'hA0 + i) begin errors++; $display("FAIL basic_pop[%0d] got=%h exp=%h", i, data, 32'hA0 + i); end
      step();
    end
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got=%b exp=0", data_valid); end
    step();
    checks++; if (status !== 8'h11) begin errors++; $display("FAIL basic_status got=%h exp=11", status); end
  endtask

  task automatic test_wrap();
    ctrl_write(8'h03);
    for (int i = 0; i < 70; i++) push_trace(i);
    step();
    checks++; if (status !== 8'hD6) begin errors++; $display("FAIL wrap_status_full got=%h exp=d6", status); end
    data_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      checks++; if (data !== 32'(6 + i)) begin errors++; $display("FAIL wrap_pop[%0d] got=%h exp=%h", i, data, 6 + i); end
      step();
    end
    data_ready = 1'b0;
    step();
    checks++; if (status !== 8'h15) begin errors++; $display("FAIL wrap_status_drained got=%h exp=15", status); end
  endtask

  task automatic test_stop_on_full();
    ctrl_write(8'h07);
    for (int i = 0; i < 65; i++) push_trace(i);
    step();
    checks++; if (status !== 8'hF6) begin errors++; $display("FAIL stop_status_frozen got=%h exp=f6", status); end
    checks++; if (inject_ready !== 1'b0) begin errors++; $display("FAIL stop_inject_ready got=%b exp=0", inject_ready); end
    push_trace(32'h99);
    data_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      checks++; if (data !== 32'(i)) begin errors++; $display("FAIL stop_pop[%0d] got=%h exp=%h", i, data, i); end
      step();
    end
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL stop_drained got=%b exp=0", data_valid); end
    ctrl_write(8'h01);
    step();
    checks++; if (status !== 8'h15) begin errors++; $display("FAIL stop_resume_status got=%h exp=15", status); end
  endtask

  task automatic test_trigger();
    ctrl_write(8'h0B);
    for (int i = 0; i < 40; i++) begin
      trace_valid = 1'b1;
      trace_data  = i;
      trigger     = (i == 10);
      step();
    end
    trace_valid = 1'b0;
    trigger     = 1'b0;
    step();
    checks++; if (status !== 8'h78) begin errors++; $display("FAIL trig_status got=%h exp=78", status); end
    data_ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      checks++; if (data !== 32'(i)) begin errors++; $display("FAIL trig_pop[%0d] got=%h exp=%h", i, data, i); end
      step();
    end
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL trig_count got=%b exp=0", data_valid); end
  endtask

  task automatic test_inject();
    ctrl_write(8'h03);
    inject_valid = 1'b1;
    inject       = 32'hDEADBEEF;
    trace_valid  = 1'b1;
    trace_data   = 32'h11;
    #1;
    checks++; if (inject_ready !== 1'b0) begin errors++; $display("FAIL inj_blocked0 got=%b exp=0", inject_ready); end
    step();
    trace_data = 32'h12;
    #1;
    checks++; if (inject_ready !== 1'b0) begin errors++; $display("FAIL inj_blocked1 got=%b exp=0", inject_ready); end
    step();
    trace_valid = 1'b0;
    #1;
    checks++; if (inject_ready !== 1'b1) begin errors++; $display("FAIL inj_gap got=%b exp=1", inject_ready); end
    step();
    inject_valid = 1'b0;
    data_ready   = 1'b1;
    checks++; if (data !== 32'h11) begin errors++; $display("FAIL inj_order0 got=%h exp=11", data); end
    step();
    checks++; if (data !== 32'h12) begin errors++; $display("FAIL inj_order1 got=%h exp=12", data); end
    step();
    checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL inj_marker got=%h exp=deadbeef", data); end
    step();
    data_ready = 1'b0;
    ctrl_write(8'h00);
    trace_valid  = 1'b1;
    trace_data   = 32'h77;
    inject_valid = 1'b1;
    inject       = 32'hCAFEF00D;
    #1;
    checks++; if (inject_ready !== 1'b1) begin errors++; $display("FAIL inj_off_ready got=%b exp=1", inject_ready); end
    step();
    trace_valid  = 1'b0;
    inject_valid = 1'b0;
    checks++; if (data_valid !== 1'b1 || data !== 32'hCAFEF00D) begin errors++; $display("FAIL inj_off_stored got=%b/%h exp=1/cafef00d", data_valid, data); end
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL inj_off_trace_ignored got=%b exp=0", data_valid); end
  endtask

  task automatic test_back_to_back();
    ctrl_write(8'h03);
    for (int i = 0; i < 64; i++) push_trace(i);
    trace_valid = 1'b1;
    data_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      trace_data = 100 + i;
      #1;
      checks++; if (data !== 32'(i)) begin errors++; $display("FAIL b2b_pop[%0d] got=%h exp=%h", i, data, i); end
      step();
    end
    trace_valid = 1'b0;
    data_ready  = 1'b0;
    step();
    checks++; if (status !== 8'hD2) begin errors++; $display("FAIL b2b_no_overflow got=%h exp=d2", status); end
    trace_valid   = 1'b1;
    trace_data    = 32'h55;
    data_ready    = 1'b1;
    control_valid = 1'b1;
    control       = 8'h03;
    step();
    trace_valid   = 1'b0;
    data_ready    = 1'b0;
    control_valid = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL clear_empty got=%b exp=0", data_valid); end
    step();
    checks++; if (status !== 8'h11) begin errors++; $display("FAIL clear_status got=%h exp=11", status); end
  endtask

  task automatic test_reset_mid_capture();
    push_trace(32'h1);
    push_trace(32'h2);
    rst          = 1'b1;
    trace_valid  = 1'b1;
    inject_valid = 1'b1;
    step();
    checks++; if (data_valid !== 1'b0 || data !== 32'h0) begin errors++; $display("FAIL midrst_data got=%b/%h exp=0/0", data_valid, data); end
    checks++; if (status_valid !== 1'b0 || status !== 8'h00) begin errors++; $display("FAIL midrst_status got=%b/%h exp=0/00", status_valid, status); end
    checks++; if (control_ready !== 1'b0 || inject_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b/%b exp=0/0", control_ready, inject_ready); end
    rst          = 1'b0;
    trace_valid  = 1'b0;
    inject_valid = 1'b0;
    step();
    step();
    checks++; if (status !== 8'h01) begin errors++; $display("FAIL midrst_after got=%h exp=01", status); end
  endtask

  initial begin
    rst           = 1'b1;
    trace_valid   = 1'b0;
    trace_data    = '0;
    trigger       = 1'b0;
    control_valid = 1'b0;
    control       = '0;
    status_ready  = 1'b1;
    data_ready    = 1'b0;
    inject_valid  = 1'b0;
    inject        = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_stop_on_full();
    test_trigger();
    test_inject();
    test_back_to_back();
    test_reset_mid_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
